// File: rtl/audio_det_pkg.sv
// Shared types and default constants for the audio level detector.
package audio_det_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LISTEN    = 2'd1,
    DETECTED  = 2'd2,
    RELEASING = 2'd3
  } det_state_t;

  localparam int unsigned DEF_WINDOW   = 4800;
  localparam logic [31:0] DEF_THRESH   = 32'd10000000;
  localparam int unsigned DEF_MIN_HITS = 2400;
  localparam int unsigned DEF_CONFIRM  = 3;
  localparam int unsigned DEF_RELEASE  = 5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audio_abs_sat.sv
// Saturating two's-complement magnitude of one 32-bit audio sample.
module audio_abs_sat (
  input  logic [31:0] sample,
  output logic [30:0] mag
);

  always_comb begin
    if (sample == 32'h8000_0000)
      mag = 31'h7FFF_FFFF;
    else if (sample[31])
      mag = ~sample[30:0] + 31'd1;
    else
      mag = sample[30:0];
  end

endmodule

// File: rtl/audio_level_detector.sv
// Windowed audio level detector with confirm/release hysteresis.
// Define AUDIO_DET_STEREO_EN to judge the louder of left/right instead of left only.
module audio_level_detector
  import audio_det_pkg::*;
#(
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter logic [31:0] THRESH   = DEF_THRESH,
  parameter int unsigned MIN_HITS = DEF_MIN_HITS,
  parameter int unsigned CONFIRM  = DEF_CONFIRM,
  parameter int unsigned RELEASE  = DEF_RELEASE
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        detected,
  output logic        window_done,
  output logic [30:0] level
);

  localparam int unsigned SW = $clog2(WINDOW + 1);
  localparam int unsigned FW = $clog2(max_u(CONFIRM, RELEASE) + 1);

  logic          s1_valid;
  logic [31:0]   s1_left;
  logic          s2_valid;
  logic [30:0]   s2_mag;
  logic [30:0]   mag_left;
  logic [30:0]   mag_sel;

  logic [SW-1:0] sample_cnt;
  logic [SW-1:0] hit_cnt;
  logic [SW-1:0] hit_total;
  logic [30:0]   peak;
  logic [30:0]   peak_next;
  logic          hit;
  logic          last_sample;
  logic          win_pass;

  det_state_t    state;
  logic [FW-1:0] pass_cnt;
  logic [FW-1:0] fail_cnt;

  assign read_audio_in = audio_in_available & enable;

  audio_abs_sat u_abs_left (.sample(s1_left), .mag(mag_left));

`ifdef AUDIO_DET_STEREO_EN
  logic [31:0] s1_right;
  logic [30:0] mag_right;

  audio_abs_sat u_abs_right (.sample(s1_right), .mag(mag_right));

  // Ties go to the left channel.
  assign mag_sel = (mag_right > mag_left) ? mag_right : mag_left;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      s1_right <= '0;
    else if (read_audio_in)
      s1_right <= right_channel_audio_in;
  end
`else
  logic unused_right;
  assign unused_right = ^right_channel_audio_in;
  assign mag_sel      = mag_left;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_left  <= '0;
      s2_valid <= 1'b0;
      s2_mag   <= '0;
    end else if (!enable) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= read_audio_in;
      if (read_audio_in)
        s1_left <= left_channel_audio_in;
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_mag <= mag_sel;
    end
  end

  assign hit         = ({1'b0, s2_mag} > THRESH);
  assign hit_total   = hit_cnt + SW'(hit);
  assign peak_next   = (s2_mag > peak) ? s2_mag : peak;
  assign last_sample = (32'(sample_cnt) == WINDOW - 1);

  // The closing sample is folded into the window result before the counters clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sample_cnt  <= '0;
      hit_cnt     <= '0;
      peak        <= '0;
      level       <= '0;
      window_done <= 1'b0;
      win_pass    <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (!enable) begin
        sample_cnt <= '0;
        hit_cnt    <= '0;
        peak       <= '0;
        win_pass   <= 1'b0;
      end else if (s2_valid) begin
        if (last_sample) begin
          sample_cnt  <= '0;
          hit_cnt     <= '0;
          peak        <= '0;
          level       <= peak_next;
          window_done <= 1'b1;
          win_pass    <= (32'(hit_total) >= MIN_HITS);
        end else begin
          sample_cnt <= sample_cnt + SW'(1);
          hit_cnt    <= hit_total;
          peak       <= peak_next;
        end
      end
    end
  end

  // state     | meaning
  // IDLE      | disabled, waiting for enable
  // LISTEN    | counting consecutive passing windows toward CONFIRM
  // DETECTED  | sound present, no failing window pending
  // RELEASING | sound present, counting consecutive failing windows toward RELEASE
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pass_cnt <= '0;
      fail_cnt <= '0;
      detected <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      pass_cnt <= '0;
      fail_cnt <= '0;
      detected <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= LISTEN;
        LISTEN: begin
          if (window_done) begin
            if (!win_pass) begin
              pass_cnt <= '0;
            end else if (pass_cnt + FW'(1) >= FW'(CONFIRM)) begin
              state    <= DETECTED;
              pass_cnt <= '0;
              detected <= 1'b1;
            end else begin
              pass_cnt <= pass_cnt + FW'(1);
            end
          end
        end
        DETECTED: begin
          if (window_done && !win_pass) begin
            if (FW'(1) >= FW'(RELEASE)) begin
              state    <= LISTEN;
              detected <= 1'b0;
            end else begin
              state    <= RELEASING;
              fail_cnt <= FW'(1);
            end
          end
        end
        RELEASING: begin
          if (window_done) begin
            if (win_pass) begin
              state    <= DETECTED;
              fail_cnt <= '0;
            end else if (fail_cnt + FW'(1) >= FW'(RELEASE)) begin
              state    <= LISTEN;
              fail_cnt <= '0;
              detected <= 1'b0;
            end else begin
              fail_cnt <= fail_cnt + FW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_level_detector.sv
// Scoreboard bench for audio_level_detector: expected window results are queued by
// the stimulus and checked by a monitor on every window_done pulse.
module tb_audio_level_detector;
  import audio_det_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        detected;
  logic        window_done;
  logic [30:0] level;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_level_detector #(
    .WINDOW(8), .THRESH(32'd100), .MIN_HITS(4), .CONFIRM(2), .RELEASE(2)
  ) dut (
    .CLOCK_50              (CLOCK_50),
    .reset                 (reset),
    .enable                (enable),
    .audio_in_available    (audio_in_available),
    .left_channel_audio_in (left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .read_audio_in         (read_audio_in),
    .detected              (detected),
    .window_done           (window_done),
    .level                 (level)
  );

  typedef struct packed {
    logic [30:0] lvl;
    logic        det;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pat_l [8];
  logic [31:0] pat_r;
  logic        det_pending = 1'b0;
  logic        det_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: level checked on the window_done cycle, detected on the following cycle.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (det_pending) begin
      check("detected_after_window", 32'(detected), 32'(det_exp));
      det_pending = 1'b0;
    end
    if (window_done) begin
      if (exp_q.size() == 0) begin
        check("window_done_unexpected", 32'(window_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("window_level", 32'(level), 32'(e.lvl));
        det_pending = 1'b1;
        det_exp     = e.det;
      end
    end
  end

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    @(negedge CLOCK_50);
    audio_in_available     = 1'b1;
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      audio_in_available = 1'b0;
    end
  endtask

  task automatic fill_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) pat_l[i] = v;
  endtask

  task automatic fill_alt(input logic [31:0] v);
    for (int i = 0; i < 8; i++) pat_l[i] = i[0] ? -v : v;
  endtask

  task automatic fill_split(input int n, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) pat_l[i] = (i < n) ? a : b;
  endtask

  task automatic run_window(input logic [30:0] lvl, input logic det, input bit gaps);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        e.lvl = lvl;
        e.det = det;
        exp_q.push_back(e);
      end
      send(pat_l[i], pat_r);
      if (i == 0) begin
        #1;
        check("read_strobe", 32'(read_audio_in), 32'd1);
      end
      if (gaps && i[0]) idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset                  = 1'b1;
    enable                 = 1'b0;
    audio_in_available     = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    pat_r                  = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_level", 32'(level), 32'd0);
    check("reset_detected", 32'(detected), 32'd0);
    check("reset_window_done", 32'(window_done), 32'd0);
    audio_in_available = 1'b1;
    #1;
    check("read_gated_by_enable", 32'(read_audio_in), 32'd0);
    @(negedge CLOCK_50);
    audio_in_available = 1'b0;
    reset  = 1'b0;
    enable = 1'b1;
    idle(3);

    // Loud windows confirm, silent windows release.
    fill_alt(32'd1000);
    run_window(31'd1000, 1'b0, 1'b0);
    run_window(31'd1000, 1'b1, 1'b0);
    fill_all(32'd0);
    run_window(31'd0, 1'b1, 1'b0);
    run_window(31'd0, 1'b0, 1'b0);
    idle(6);
    check("state_listen_after_release", 32'(dut.state), 32'(LISTEN));

    // Threshold and MIN_HITS boundaries, failing window clears pass count.
    fill_all(32'd100);
    run_window(31'd100, 1'b0, 1'b0);
    fill_split(4, 32'd101, 32'd100);
    run_window(31'd101, 1'b0, 1'b0);
    fill_split(3, 32'd101, 32'd100);
    run_window(31'd101, 1'b0, 1'b0);
    fill_all(32'h8000_0000);
    run_window(31'h7FFF_FFFF, 1'b0, 1'b0);
    fill_alt(32'd1000);
    run_window(31'd1000, 1'b1, 1'b1);
    idle(6);

    // Enable drop with a partial window and a loud sample still in flight.
    for (int i = 0; i < 4; i++) send(32'd1000, 32'd0);
    send(32'd5000, 32'd0);
    @(negedge CLOCK_50);
    enable = 1'b0;
    #1;
    check("read_while_disabled", 32'(read_audio_in), 32'd0);
    idle(3);
    check("detected_after_disable", 32'(detected), 32'd0);
    check("level_held_after_disable", 32'(level), 32'd1000);
    @(negedge CLOCK_50);
    enable = 1'b1;
    idle(2);
    fill_alt(32'd1000);
    run_window(31'd1000, 1'b0, 1'b0);
    run_window(31'd1000, 1'b1, 1'b0);
    idle(6);

    // Reset after five samples of a window.
    for (int i = 0; i < 5; i++) send(32'd300, 32'd0);
    @(negedge CLOCK_50);
    audio_in_available = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("midwin_reset_level", 32'(level), 32'd0);
    check("midwin_reset_detected", 32'(detected), 32'd0);
    check("midwin_reset_window_done", 32'(window_done), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    idle(2);
    fill_all(32'd0);
    pat_l[7] = 32'd200;
    run_window(31'd200, 1'b0, 1'b0);

    // Right channel louder than left.
    fill_all(32'd50);
    pat_r = -32'd500;
`ifdef AUDIO_DET_STEREO_EN
    run_window(31'd500, 1'b0, 1'b0);
`else
    run_window(31'd50, 1'b0, 1'b0);
`endif
    pat_r = '0;
    idle(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_level_detector.md
AUDIO_LEVEL_DETECTOR -- requirements
Module: audio_level_detector

Interface
REQ-001 Parameter WINDOW, default 4800, SHALL set the number of samples per analysis window (0.1 s at 48 kHz).
REQ-002 Parameter THRESH, default 32'd10000000, SHALL set the magnitude a sample must exceed to count as a hit.
REQ-003 Parameter MIN_HITS, default 2400, SHALL set the hits per window needed for the window to pass.
REQ-004 Parameter CONFIRM, default 3, SHALL set the consecutive passing windows needed to declare detection.
REQ-005 Parameter RELEASE, default 5, SHALL set the consecutive failing windows needed to clear detection.
REQ-006 The ports SHALL be as follows (clock and reset first):
- CLOCK_50  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  listening enable.
- audio_in_available  in  1  Audio_Controller has a sample pair.
- left_channel_audio_in  in  32  signed left sample.
- right_channel_audio_in  in  32  signed right sample.
- read_audio_in  out  1  sample consume strobe.
- detected  out  1  sustained sound present.
- window_done  out  1  one-cycle pulse at each window end.
- level  out  31  peak magnitude of the last completed window.

Function
REQ-007 read_audio_in SHALL equal audio_in_available & enable, combinationally; a sample SHALL be consumed in exactly the cycles where it is 1.
REQ-008 The selected sample SHALL be registered on consume, and its magnitude SHALL be registered on the next cycle (2-stage pipeline). Total latency from consume to the counter update SHALL be 2 cycles.
REQ-009 Magnitude SHALL be the two's-complement absolute value. The input 32'h80000000 SHALL saturate to 31'h7FFFFFFF.
REQ-010 A hit SHALL be a magnitude strictly greater than THRESH. A magnitude equal to THRESH SHALL NOT be a hit.
REQ-011 The sample counter SHALL count 0..WINDOW-1. The hit counter and the running peak SHALL accumulate in parallel.
- On the WINDOW-th sample the sample counter SHALL wrap to 0.
- window_done SHALL pulse for 1 cycle.
- level SHALL load the window peak.
- The hit counter and the peak SHALL clear; the last sample SHALL be included in that window's result.
REQ-012 The FSM states SHALL be IDLE, LISTEN, DETECTED and RELEASING.
- IDLE->LISTEN when enable=1.
- LISTEN: passing windows SHALL increment pass_cnt, and a failing window SHALL clear it. pass_cnt==CONFIRM SHALL move the FSM to DETECTED.
- DETECTED: a failing window SHALL move the FSM to RELEASING with fail_cnt=1.
- RELEASING: a passing window SHALL return the FSM to DETECTED and clear fail_cnt. fail_cnt==RELEASE SHALL move the FSM to LISTEN.
REQ-013 detected SHALL be 1 in DETECTED and RELEASING, registered, and SHALL update in the cycle after window_done.
REQ-014 When enable falls in any state, the FSM SHALL go to IDLE next cycle. All counters and the peak SHALL clear, and detected SHALL drop. level SHALL hold its value. A partial window SHALL be discarded.
REQ-015 When enable falls while a sample is in the pipeline, that sample SHALL be discarded.
REQ-016 Samples arriving on back-to-back cycles SHALL each be processed with no loss.
REQ-017 Counter widths SHALL be $clog2(WINDOW+1) and $clog2(max(CONFIRM,RELEASE)+1). Counters SHALL NOT overflow for any legal parameters.

Reset
REQ-018 Reset SHALL asynchronously force IDLE and clear all counters, the pipeline, level, detected and window_done.
REQ-019 Reset asserted mid-window SHALL discard that window. The first window after release SHALL start at sample 0.

Configuration
REQ-020 With AUDIO_DET_STEREO_EN defined, the selected sample SHALL be whichever of |left| and |right| is greater. A tie SHALL select left.
REQ-021 With AUDIO_DET_STEREO_EN undefined, only the left channel SHALL be used, and right_channel_audio_in SHALL be ignored but still present as a port.

Structure
REQ-022 The package audio_det_pkg SHALL hold the FSM state enum and the default constants (WINDOW, THRESH, MIN_HITS, CONFIRM, RELEASE).
REQ-023 The sub-module audio_abs_sat SHALL implement the saturating absolute value, instanced once per channel used.

Verification
REQ-024 Bench scenarios (WINDOW=8, MIN_HITS=4, CONFIRM=2, RELEASE=2, THRESH=100) SHALL include:
- Alternating ±1000 samples, enable=1 -> detected=1 the cycle after the 2nd window_done; level=1000.
- Detected, then samples of 0 -> detected=0 after the 2nd failing window_done; the FSM is in LISTEN.
- Samples exactly 100 -> no hits, detected stays 0; samples 101 -> hits counted.
- Sample 32'h80000000 -> level=31'h7FFFFFFF at window end.
- Reset asserted at sample 5 of a window -> all outputs 0 immediately; the next window_done occurs 8 samples after reset release.
- STEREO_EN: left=50, right=-500 for a full window -> the window passes and level=500. Without the macro -> the window fails and level=50.
